// File: rtl/sym_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sym_sequencer_pkg
// Description : Shared symbol width, blank code and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sym_sequencer_pkg;

  localparam int CODE_W = 5;

  // Code that renders as an unlit digit on the downstream segment decoder
  localparam logic [CODE_W-1:0] BLANK_CODE = 5'b11111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sym_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : sym_dwell_timer
// Description : Auto-reloading down-counter that pulses o_expire on the last
//               cycle of every dwell period of (i_load_val + 1) cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_dwell_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_enable,
  output logic             o_expire
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_cnt;

  // Latch the period on load; while enabled count down and reload at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= i_load_val;
      r_cnt    <= i_load_val;
    end else if (i_enable) begin
      if (r_cnt == '0) r_cnt <= r_period;
      else             r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sym_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sym_sequencer
// Description : Message buffer of 5-bit symbol codes played back one symbol
//               per dwell period, with optional looping and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_sequencer
  import sym_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [CODE_W-1:0]          wr_code,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic [DIV_W-1:0]           dwell,
  output logic [CODE_W-1:0]          code,
  output logic                       code_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [IDX_W-1:0]    r_idx;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_load;
  logic                w_expire;
  logic                w_last;
  logic                w_wr_fire;
  logic [DIV_W-1:0]    w_load_val;
  logic [CODE_W-1:0]   r_buf [DEPTH];

  assign wr_ready   = (r_state == IDLE) && (r_count < CNT_W'(DEPTH));
  assign w_wr_fire  = wr_valid && wr_ready && !clear;
  assign w_last     = ({1'b0, r_idx} == (r_count - CNT_W'(1)));
  // A zero dwell behaves as a one-cycle dwell
  assign w_load_val = (dwell == '0) ? '0 : (dwell - DIV_W'(1));

  sym_dwell_timer #(
    .DIV_W (DIV_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_enable   (r_state == PLAY),
    .o_expire   (w_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; stop overrides an end-of-message expiry so no done
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop && (r_count != '0)) begin
          w_state_nxt = PLAY;
          w_load      = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_expire && w_last && !loop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Symbol index: advance on expiry, wrap to zero at the end or when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if ((r_state != PLAY) || stop) begin
      r_idx <= '0;
    end else if (w_expire) begin
      r_idx <= w_last ? '0 : (r_idx + IDX_W'(1));
    end
  end

  // Fill level: clear wins over a same-cycle write, both only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_count <= '0;
    else if ((r_state == IDLE) && clear) r_count <= '0;
    else if (w_wr_fire)                 r_count <= r_count + CNT_W'(1);
  end

  // End-of-message pulse, registered so it lines up with the first idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_done_nxt;
  end

  // Message storage; contents survive reset and are overwritten in place
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_buf[r_count[IDX_W-1:0]] <= wr_code;
  end

  assign code       = (r_state == PLAY) ? r_buf[r_idx] : BLANK_CODE;
  assign code_valid = (r_state == PLAY);
  assign busy       = (r_state == PLAY);
  assign done       = r_done;
  assign count      = r_count;

endmodule
`default_nettype wire
